// File: rtl/sync_fifo_gen_pkg.sv
// rtl/sync_fifo_gen_pkg.sv - shared constants, error-flag positions and log2 helper for sync_fifo_gen
package sync_fifo_gen_pkg;

  localparam int DEFAULT_WIDTH = 66;
  localparam int DEFAULT_DEPTH = 32;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;
  localparam int ERR_W   = 2;

  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_gen_ram.sv
// rtl/sync_fifo_gen_ram.sv - 1W1R storage array, synchronous write, asynchronous read
module sync_fifo_gen_ram
  import sync_fifo_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = log2_ceil(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_gen.sv
// rtl/sync_fifo_gen.sv - parametrised single-clock FIFO with thresholds, flush and sticky errors
// FIFO_OREG_EN adds a registered one-word output stage in front of data_o.
module sync_fifo_gen
  import sync_fifo_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             err_clr_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             afull_o,
  output logic             aempty_o,
  input  logic [CNT_W-1:0] afull_thr_i,
  input  logic [CNT_W-1:0] aempty_thr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int AW = log2_ceil(DEPTH);

  logic [CNT_W-1:0] wptr, rptr, arr_cnt;
  logic [WIDTH-1:0] ram_rdata;
  logic [ERR_W-1:0] err_q, err_d;
  logic             wr_acc, rd_acc, pop;

  assign arr_cnt = wptr - rptr;
  assign wr_acc  = wr_i & ~full_o;
  assign rd_acc  = rd_i & ~empty_o;

  sync_fifo_gen_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~clr_i),
    .waddr (wptr[AW-1:0]),
    .wdata (data_i),
    .raddr (rptr[AW-1:0]),
    .rdata (ram_rdata)
  );

`ifdef FIFO_OREG_EN
  logic [WIDTH-1:0] oreg_q;
  logic             oreg_valid;

  // Refill whenever the stage is free or being drained this cycle.
  assign pop     = (~oreg_valid | rd_acc) & (arr_cnt != '0);
  assign count_o = arr_cnt + {{(CNT_W-1){1'b0}}, oreg_valid};
  assign empty_o = ~oreg_valid;
  assign data_o  = oreg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oreg_valid <= 1'b0;
      oreg_q     <= '0;
    end else if (clr_i) begin
      oreg_valid <= 1'b0;
    end else if (pop) begin
      oreg_valid <= 1'b1;
      oreg_q     <= ram_rdata;
    end else if (rd_acc) begin
      oreg_valid <= 1'b0;
    end
  end
`else
  assign pop     = rd_acc;
  assign count_o = arr_cnt;
  assign empty_o = (arr_cnt == '0);
  assign data_o  = ram_rdata;
`endif

  assign full_o   = (count_o == CNT_W'(DEPTH));
  assign afull_o  = (count_o >= afull_thr_i);
  assign aempty_o = (count_o <= aempty_thr_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + CNT_W'(1);
      if (pop)    rptr <= rptr + CNT_W'(1);
    end
  end

  // A fresh error event outranks err_clr_i; flush outranks both.
  always_comb begin
    err_d = err_q;
    if (err_clr_i)          err_d = '0;
    if (wr_i & full_o)      err_d[ERR_OVF] = 1'b1;
    if (rd_i & empty_o)     err_d[ERR_UNF] = 1'b1;
    if (clr_i)              err_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign overflow_o  = err_q[ERR_OVF];
  assign underflow_o = err_q[ERR_UNF];

endmodule

// File: tb/tb_sync_fifo_gen.sv
// tb/tb_sync_fifo_gen.sv - directed self-checking bench for sync_fifo_gen
module tb_sync_fifo_gen;

  localparam int WIDTH = 66;
  localparam int DEPTH = 32;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_i = 1'b0;
  logic             err_clr_i = 1'b0;
  logic             wr_i = 1'b0;
  logic             rd_i = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic [WIDTH-1:0] data_o;
  logic             full_o, empty_o, afull_o, aempty_o, overflow_o, underflow_o;
  logic [CNT_W-1:0] afull_thr_i = CNT_W'(24);
  logic [CNT_W-1:0] aempty_thr_i = CNT_W'(4);
  logic [CNT_W-1:0] count_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] exp_word;

  sync_fifo_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (clr_i),
    .err_clr_i    (err_clr_i),
    .wr_i         (wr_i),
    .data_i       (data_i),
    .rd_i         (rd_i),
    .data_o       (data_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .afull_o      (afull_o),
    .aempty_o     (aempty_o),
    .afull_thr_i  (afull_thr_i),
    .aempty_thr_i (aempty_thr_i),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .underflow_o  (underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [WIDTH-1:0] d);
    wr_i = w;
    rd_i = r;
    data_i = d;
    @(posedge clk);
    #1;
    wr_i = 1'b0;
    rd_i = 1'b0;
    clr_i = 1'b0;
    err_clr_i = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_count", 128'(count_o), 128'd0);
    chk("rst_empty", 128'(empty_o), 128'd1);
    chk("rst_full", 128'(full_o), 128'd0);
    chk("rst_aempty", 128'(aempty_o), 128'd1);
    chk("rst_afull", 128'(afull_o), 128'd0);
    chk("rst_ovf", 128'(overflow_o), 128'd0);
    chk("rst_unf", 128'(underflow_o), 128'd0);
    #10 rst_n = 1'b1;

    // fill to full, checking thresholds 24/4 at every step
    for (int k = 0; k < DEPTH; k++) begin
      cyc(1'b1, 1'b0, WIDTH'(k));
      chk("fill_count", 128'(count_o), 128'(k + 1));
      chk("fill_afull", 128'(afull_o), 128'((k + 1) >= 24));
      chk("fill_aempty", 128'(aempty_o), 128'((k + 1) <= 4));
    end
    chk("full_flag", 128'(full_o), 128'd1);
    cyc(1'b1, 1'b0, WIDTH'(8'hAA));
    chk("ovf_set", 128'(overflow_o), 128'd1);
    chk("ovf_count", 128'(count_o), 128'd32);
    cyc(1'b0, 1'b0, '0);
    chk("ovf_sticky", 128'(overflow_o), 128'd1);
    err_clr_i = 1'b1;
    cyc(1'b0, 1'b0, '0);
    chk("ovf_clr", 128'(overflow_o), 128'd0);

    for (int k = 0; k < DEPTH; k++) begin
      chk("drain_data", 128'(data_o), 128'(k));
      cyc(1'b0, 1'b1, '0);
    end
    chk("drain_empty", 128'(empty_o), 128'd1);
    chk("drain_count", 128'(count_o), 128'd0);
    chk("drain_ovf", 128'(overflow_o), 128'd0);
    chk("drain_unf", 128'(underflow_o), 128'd0);

    // simultaneous write+read on empty
    cyc(1'b1, 1'b1, WIDTH'(5));
    chk("we_count", 128'(count_o), 128'd1);
    chk("we_unf", 128'(underflow_o), 128'd1);
`ifdef FIFO_OREG_EN
    chk("we_empty_lat1", 128'(empty_o), 128'd1);
`endif
    cyc(1'b0, 1'b0, '0);
    chk("we_data", 128'(data_o), 128'd5);
    chk("we_empty", 128'(empty_o), 128'd0);
    err_clr_i = 1'b1;
    cyc(1'b0, 1'b1, '0);
    chk("we_unf_clr", 128'(underflow_o), 128'd0);
    chk("we_drained", 128'(empty_o), 128'd1);

    // steady streaming at count 16 across pointer wrap
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b0, WIDTH'(100 + k));
      q.push_back(WIDTH'(100 + k));
    end
    cyc(1'b0, 1'b0, '0);
    for (int k = 0; k < 100; k++) begin
      exp_word = q.pop_front();
      chk("stream_data", 128'(data_o), 128'(exp_word));
      cyc(1'b1, 1'b1, WIDTH'(200 + k));
      q.push_back(WIDTH'(200 + k));
      chk("stream_count", 128'(count_o), 128'd16);
    end
    chk("stream_ovf", 128'(overflow_o), 128'd0);
    chk("stream_unf", 128'(underflow_o), 128'd0);

    // flush overrides a concurrent write/read
    clr_i = 1'b1;
    cyc(1'b1, 1'b1, WIDTH'(7));
    chk("clr_count", 128'(count_o), 128'd0);
    chk("clr_empty", 128'(empty_o), 128'd1);
    chk("clr_unf", 128'(underflow_o), 128'd0);
    chk("clr_ovf", 128'(overflow_o), 128'd0);

    // threshold boundaries
    afull_thr_i = '0;
    aempty_thr_i = '0;
    #1;
    chk("thr0_afull", 128'(afull_o), 128'd1);
    chk("thr0_aempty", 128'(aempty_o), 128'd1);
    afull_thr_i = CNT_W'(24);
    aempty_thr_i = CNT_W'(4);

    // output-stage latency, then asynchronous reset mid-stream
    cyc(1'b0, 1'b1, '0);
    chk("unf_pre_rst", 128'(underflow_o), 128'd1);
    cyc(1'b1, 1'b0, WIDTH'(9));
`ifdef FIFO_OREG_EN
    chk("oreg_lat1", 128'(empty_o), 128'd1);
    cyc(1'b0, 1'b0, '0);
    chk("oreg_lat2", 128'(empty_o), 128'd0);
`else
    chk("comb_lat1", 128'(empty_o), 128'd0);
`endif
    cyc(1'b1, 1'b0, WIDTH'(10));
    cyc(1'b1, 1'b0, WIDTH'(11));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 128'(count_o), 128'd0);
    chk("arst_empty", 128'(empty_o), 128'd1);
    chk("arst_aempty", 128'(aempty_o), 128'd1);
    chk("arst_full", 128'(full_o), 128'd0);
    chk("arst_unf", 128'(underflow_o), 128'd0);
    chk("arst_ovf", 128'(overflow_o), 128'd0);
    #2 rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_gen.md
# sync_fifo_gen

Parametrised single-clock FIFO: the next-generation buffer for compressor datapaths, replacing the fixed 66-bit/32-entry FIFOs. It adds:
- programmable almost-full/almost-empty thresholds;
- an occupancy count;
- a synchronous flush;
- clearable sticky error flags;
- an optional registered read port.

It sits between compressor pipeline stages wherever rate decoupling or back-pressure is needed.

## Interface
Parameters:
- WIDTH, 66, data word width in bits (>=1)
- DEPTH, 32, number of storage entries; power of two, >=2
- CNT_W, $clog2(DEPTH)+1, width of count and threshold signals

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clr_i  input  1  synchronous flush
- err_clr_i  input  1  synchronous clear of sticky error flags
- wr_i  input  1  write request
- data_i  input  WIDTH  write data
- rd_i  input  1  read request (pops head word)
- data_o  output  WIDTH  head word, show-ahead; valid while empty_o=0
- full_o  output  1  count_o == DEPTH
- empty_o  output  1  no word available at data_o
- afull_o  output  1  count_o >= afull_thr_i
- aempty_o  output  1  count_o <= aempty_thr_i
- afull_thr_i  input  CNT_W  almost-full threshold, quasi-static
- aempty_thr_i  input  CNT_W  almost-empty threshold, quasi-static
- count_o  output  CNT_W  words held (0..DEPTH)
- overflow_o  output  1  sticky: write attempted while full
- underflow_o  output  1  sticky: read attempted while empty

## Operation
- Pointers wptr and rptr are CNT_W bits wide and wrap naturally modulo 2*DEPTH. The low $clog2(DEPTH) bits address the array.
- count_o = wptr - rptr, computed modulo 2^CNT_W.
- Accepted write: wr_i & ~full_o. Array is written at wptr; wptr increments.
- Accepted read: rd_i & ~empty_o. The head is consumed; the pointer or output stage advances.
- Rejected write: wr_i & full_o. Data is dropped; overflow_o sets on the next edge.
- Rejected read: rd_i & empty_o. No state change; underflow_o sets on the next edge.
- Simultaneous wr_i and rd_i: each is judged independently against the current flags.
  - At full: the read is accepted, the write is rejected, and overflow is set.
  - At empty: the write is accepted, the read is rejected, and underflow is set.
  - Otherwise both are accepted and count_o is unchanged.
- clr_i has priority over everything else:
  - pointers go to 0 and the output stage is invalidated;
  - overflow_o and underflow_o are cleared;
  - wr_i and rd_i in the same cycle are ignored and set no error.
- err_clr_i clears both sticky flags. A new error event in the same cycle wins, so the flag stays 1.
- All flags and count_o depend only on registered state. There is no combinational path from wr_i or rd_i to any output.
- Threshold inputs feed a combinational comparison. Any threshold value is legal. afull_thr_i=0 forces afull_o=1.
- Reset values: pointers 0, count_o=0, empty_o=1, aempty_o=1, full_o=0, overflow_o=0, underflow_o=0.
- afull_o follows its compare immediately after reset.
- data_o is undefined while empty_o=1.

## Timing
- Without FIFO_OREG_EN: data_o = array[rptr] combinationally.
  - A write to an empty FIFO at edge N gives empty_o=0 and valid data_o after edge N.
  - A read pop takes effect at the same edge.
- full_o, afull_o, aempty_o and count_o all update on the edge that performs the accepted access.
- Throughput is one write and one read per cycle, sustained.

## Configuration
- Macro FIFO_OREG_EN: adds a one-word output register between the array and data_o.
- With the macro:
  - data_o and empty_o are register outputs (empty_o = ~oreg_valid).
  - The register refills from the array whenever it is empty or popped and the array holds a word.
  - count_o includes the output-register word, so full_o is still count_o==DEPTH.
  - Latency from a write into an empty FIFO to empty_o=0 is 2 edges.
  - Back-to-back reads remain full-rate.
- Without the macro: combinational show-ahead read, with 1-edge latency.

## Structure
- Package sync_fifo_gen_pkg holds:
  - default WIDTH and DEPTH constants;
  - error-flag bit positions;
  - a log2 helper function.
- Sub-module sync_fifo_gen_ram: a 1W1R storage array with synchronous write and asynchronous read, addressed by the pointer low bits.

## Test plan
- Reset, then write 32 words 0..31 (DEPTH=32) -> full_o=1, count_o=32. Read 32 -> data 0..31 in order, empty_o=1, no errors.
- Full FIFO, wr_i=1 with data 0xAA -> word dropped, overflow_o=1 and sticky. err_clr_i pulse -> overflow_o=0.
- Empty FIFO, wr_i and rd_i together with data 5 -> count_o=1, underflow_o=1, data_o=5.
- Thresholds 24/4 -> afull_o rises exactly when the 24th word is stored; aempty_o falls on the 5th word.
- Run 100 cycles of simultaneous read and write at count 16 -> count_o stays 16 and ordering is preserved across the pointer wrap. Then pulse clr_i -> count_o=0, empty_o=1.
- FIFO_OREG_EN: write to an empty FIFO -> empty_o falls 2 edges later. rst_n asserted mid-stream -> all outputs return to their reset values asynchronously.
